// File: rtl/sram_voice_scheduler.sv
// Shares one async SRAM read port among NUM_VOICES one-shot sample voices.
// Each sample tick reads one word per active voice, mixes with saturation and emits one audio word.
module sram_voice_scheduler_lane #(
    parameter int ADDR_W = 20
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              tick,
    input  logic              req,
    input  logic              capt,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] rd_offset,
    output logic              active
);
    logic [ADDR_W-1:0] offset;
    logic              done, prev_req, rise, done_next;

    assign rise      = req & ~prev_req;
    assign done_next = req & prev_req & done;
    assign active    = req & ~done_next & (len != '0);
    // A voice restarting on this tick must read offset 0 before the register catches up.
    assign rd_offset = (tick & rise) ? '0 : offset;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            offset   <= '0;
            done     <= 1'b0;
            prev_req <= 1'b0;
        end else if (tick) begin
            prev_req <= req;
            if (rise) begin
                offset <= '0;
                done   <= 1'b0;
            end else if (!req) begin
                done <= 1'b0;
            end
        end else if (capt) begin
            if (offset == len - ADDR_W'(1)) done   <= 1'b1;
            else                            offset <= offset + ADDR_W'(1);
        end
    end
endmodule

module sram_voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int READ_WAIT  = 2
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         sample_tick,
    input  logic [NUM_VOICES-1:0]        voice_req,
    input  logic [NUM_VOICES*ADDR_W-1:0] voice_base,
    input  logic [NUM_VOICES*ADDR_W-1:0] voice_len,
    input  logic [DATA_W-1:0]            sram_data,
    output logic [ADDR_W-1:0]            sram_addr,
    output logic                         OE,
    output logic [DATA_W-1:0]            audio_data,
    output logic                         sample_valid,
    output logic                         busy,
    output logic                         overrun,
    output logic [NUM_VOICES-1:0]        voice_active
);
    localparam int VI_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W = DATA_W + $clog2(NUM_VOICES);
    localparam int WC_W  = $clog2(READ_WAIT + 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DATA_W-1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_CAPT, S_OUT} state_t;

    state_t                               state, state_nxt;
    logic [VI_W-1:0]                      cur, sel;
    logic                                 found;
    logic [NUM_VOICES-1:0]                active_nxt, sel_mask;
    logic [WC_W-1:0]                      wait_cnt;
    logic signed [ACC_W-1:0]              acc, acc_sum, acc_fin;
    logic [NUM_VOICES-1:0][ADDR_W-1:0]    base_arr, len_arr, rd_off;
    logic                                 tick_idle;

    assign base_arr  = voice_base;
    assign len_arr   = voice_len;
    assign tick_idle = sample_tick & (state == S_IDLE);

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_lane
        sram_voice_scheduler_lane #(.ADDR_W(ADDR_W)) u_lane (
            .Clk       (Clk),
            .Reset     (Reset),
            .tick      (tick_idle),
            .req       (voice_req[i]),
            .capt      ((state == S_CAPT) && (cur == VI_W'(i))),
            .len       (len_arr[i]),
            .rd_offset (rd_off[i]),
            .active    (active_nxt[i])
        );
    end

    function automatic logic [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)      return {1'b0, {(DATA_W-1){1'b1}}};
        else if (v < SAT_MIN) return {1'b1, {(DATA_W-1){1'b0}}};
        else                  return v[DATA_W-1:0];
    endfunction

    assign acc_sum = acc + ACC_W'($signed(sram_data));
    assign acc_fin = (state == S_CAPT) ? acc_sum : acc;

    // Next voice to read: lowest active at a tick, otherwise next higher than the current one.
    always_comb begin
        sel_mask = (state == S_IDLE) ? active_nxt : voice_active;
        found    = 1'b0;
        sel      = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!found && sel_mask[i] && ((state == S_IDLE) || (VI_W'(i) > cur))) begin
                found = 1'b1;
                sel   = VI_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (sample_tick) state_nxt = found ? S_ADDR : S_OUT;
            S_ADDR:  state_nxt = S_WAIT;
            S_WAIT:  if (wait_cnt == WC_W'(READ_WAIT - 1)) state_nxt = S_CAPT;
            S_CAPT:  state_nxt = found ? S_ADDR : S_OUT;
            S_OUT:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign OE           = !((state == S_ADDR) || (state == S_WAIT) || (state == S_CAPT));
    assign busy         = (state != S_IDLE);
    assign sample_valid = (state == S_OUT);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= S_IDLE;
            cur          <= '0;
            wait_cnt     <= '0;
            acc          <= '0;
            sram_addr    <= '0;
            audio_data   <= '0;
            overrun      <= 1'b0;
            voice_active <= '0;
        end else begin
            state <= state_nxt;
            if (sample_tick && (state != S_IDLE)) overrun <= 1'b1;
            if (tick_idle) voice_active <= active_nxt;
            if (state_nxt == S_ADDR) begin
                cur       <= sel;
                sram_addr <= base_arr[sel] + rd_off[sel];
            end
            if (state == S_ADDR)      wait_cnt <= '0;
            else if (state == S_WAIT) wait_cnt <= wait_cnt + WC_W'(1);
            if (state == S_CAPT)     acc <= acc_sum;
            else if (state == S_OUT) acc <= '0;
            // Load the mix on entry to OUT so it is valid while sample_valid is high.
            if ((state_nxt == S_OUT) && (state != S_OUT)) audio_data <= sat(acc_fin);
        end
    end
endmodule
